// File: rtl/mp64_nic_uart_bridge.sv
// NIC PHY-port to UART bridge: NIC bursts become length-prefixed UART packets and back.
// Optional trailing checksum byte per packet when MP64_NIC_BRIDGE_CSUM_EN is defined.
module mp64_nic_uart_bridge #(
   parameter int unsigned MTU        = 1500,
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned RX_TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        nic_tx_valid,
   input  logic [7:0]  nic_tx_data,
   output logic        nic_tx_ready,
   output logic        nic_rx_valid,
   output logic [7:0]  nic_rx_data,
   input  logic        nic_rx_ready,
   output logic        link_up,
   output logic        uart_tx_valid,
   output logic [7:0]  uart_tx_data,
   input  logic        uart_tx_ready,
   input  logic        uart_rx_valid,
   input  logic [7:0]  uart_rx_data,
   output logic [15:0] tx_frames,
   output logic [15:0] rx_frames,
   output logic [15:0] rx_drops,
   output logic [15:0] tx_drops
);

   localparam int unsigned AW = $clog2(MTU + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
   localparam int unsigned TW = $clog2(RX_TIMEOUT + 1);

   typedef enum logic [2:0] {
      E_IDLE,
      E_CAPTURE,
      E_LEN_LO,
      E_LEN_HI,
`ifdef MP64_NIC_BRIDGE_CSUM_EN
      E_PAYLOAD,
      E_CSUM
`else
      E_PAYLOAD
`endif
   } e_state_t;

   typedef enum logic [2:0] {
      I_LEN_LO,
      I_LEN_HI,
      I_PAYLOAD,
`ifdef MP64_NIC_BRIDGE_CSUM_EN
      I_CSUM,
`endif
      I_WAIT,
      I_STREAM
   } i_state_t;

   // ---------------- egress ----------------
   e_state_t         e_state;
   logic [AW-1:0]    e_count;
   logic [AW-1:0]    e_idx;
   logic [GW-1:0]    e_gap;
   logic             e_trunc;
   logic [7:0]       e_csum;
   logic [15:0]      e_len;
   logic [7:0]       tx_rd;
   logic             tx_wr;
   logic [AW-1:0]    tx_waddr;
   logic [7:0]       tx_buf [MTU];

   assign e_len    = 16'(e_count);
   assign tx_rd    = tx_buf[e_idx];
   assign tx_wr    = nic_tx_valid && nic_tx_ready &&
                     ((e_state == E_IDLE) || ((e_state == E_CAPTURE) && (e_count != AW'(MTU))));
   assign tx_waddr = (e_state == E_IDLE) ? '0 : e_count;

   always_ff @(posedge clk) begin
      if (tx_wr) tx_buf[tx_waddr] <= nic_tx_data;
   end

   // Capture until the line goes quiet, then replay header, payload and optional checksum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_state       <= E_IDLE;
         e_count       <= '0;
         e_idx         <= '0;
         e_gap         <= '0;
         e_trunc       <= 1'b0;
         e_csum        <= '0;
         nic_tx_ready  <= 1'b0;
         uart_tx_valid <= 1'b0;
         uart_tx_data  <= '0;
         tx_frames     <= '0;
         tx_drops      <= '0;
      end else begin
         case (e_state)
            E_IDLE: begin
               nic_tx_ready <= 1'b1;
               if (nic_tx_valid && nic_tx_ready) begin
                  e_count <= AW'(1);
                  e_gap   <= '0;
                  e_trunc <= 1'b0;
                  e_csum  <= nic_tx_data;
                  e_state <= E_CAPTURE;
               end
            end
            E_CAPTURE: begin
               if (nic_tx_valid) begin
                  e_gap <= '0;
                  if (e_count == AW'(MTU)) begin
                     e_trunc <= 1'b1;
                  end else begin
                     e_count <= e_count + AW'(1);
                     e_csum  <= e_csum + nic_tx_data;
                  end
               end else if (e_gap == GW'(GAP_CYCLES - 1)) begin
                  if (e_trunc) begin
                     tx_drops <= tx_drops + 16'd1;
                     e_state  <= E_IDLE;
                  end else begin
                     nic_tx_ready  <= 1'b0;
                     uart_tx_valid <= 1'b1;
                     uart_tx_data  <= e_len[7:0];
                     e_idx         <= '0;
                     e_state       <= E_LEN_LO;
                  end
               end else begin
                  e_gap <= e_gap + GW'(1);
               end
            end
            E_LEN_LO: begin
               if (uart_tx_ready) begin
                  uart_tx_data <= e_len[15:8];
                  e_state      <= E_LEN_HI;
               end
            end
            E_LEN_HI: begin
               if (uart_tx_ready) begin
                  uart_tx_data <= tx_rd;
                  e_idx        <= e_idx + AW'(1);
                  e_state      <= E_PAYLOAD;
               end
            end
            E_PAYLOAD: begin
               if (uart_tx_ready) begin
                  if (e_idx == e_count) begin
`ifdef MP64_NIC_BRIDGE_CSUM_EN
                     uart_tx_data  <= e_csum;
                     e_state       <= E_CSUM;
`else
                     uart_tx_valid <= 1'b0;
                     tx_frames     <= tx_frames + 16'd1;
                     nic_tx_ready  <= 1'b1;
                     e_state       <= E_IDLE;
`endif
                  end else begin
                     uart_tx_data <= tx_rd;
                     e_idx        <= e_idx + AW'(1);
                  end
               end
            end
`ifdef MP64_NIC_BRIDGE_CSUM_EN
            E_CSUM: begin
               if (uart_tx_ready) begin
                  uart_tx_valid <= 1'b0;
                  tx_frames     <= tx_frames + 16'd1;
                  nic_tx_ready  <= 1'b1;
                  e_state       <= E_IDLE;
               end
            end
`endif
            default: e_state <= E_IDLE;
         endcase
      end
   end

   // ---------------- ingress ----------------
   i_state_t         i_state;
   logic [15:0]      i_len;
   logic [AW-1:0]    i_count;
   logic [AW-1:0]    i_idx;
   logic [TW-1:0]    i_timer;
   logic [7:0]       i_csum;
   logic [15:0]      rx_len;
   logic             rx_timeout;
   logic             payload_last;
   logic             stream_done;
   logic [7:0]       rx_rd;
   logic             rx_wr;
   logic [7:0]       rx_buf [MTU];

   assign rx_len       = {uart_rx_data, i_len[7:0]};
   assign rx_timeout   = (i_timer == TW'(RX_TIMEOUT - 1));
   assign payload_last = (16'(i_count) == (i_len - 16'd1));
   assign stream_done  = (16'(i_idx) == i_len);
   assign rx_rd        = rx_buf[i_idx];
   assign rx_wr        = uart_rx_valid && (i_state == I_PAYLOAD);

   always_ff @(posedge clk) begin
      if (rx_wr) rx_buf[i_count] <= uart_rx_data;
   end

   // Buffer a whole packet, then stream it to the NIC without bubbles once it is ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_state      <= I_LEN_LO;
         i_len        <= '0;
         i_count      <= '0;
         i_idx        <= '0;
         i_timer      <= '0;
         i_csum       <= '0;
         nic_rx_valid <= 1'b0;
         nic_rx_data  <= '0;
         rx_frames    <= '0;
         rx_drops     <= '0;
      end else begin
         case (i_state)
            I_LEN_LO: begin
               if (uart_rx_valid) begin
                  i_len[7:0] <= uart_rx_data;
                  i_timer    <= '0;
                  i_state    <= I_LEN_HI;
               end
            end
            I_LEN_HI: begin
               if (uart_rx_valid) begin
                  if ((rx_len == 16'd0) || (rx_len > 16'(MTU))) begin
                     rx_drops <= rx_drops + 16'd1;
                     i_state  <= I_LEN_LO;
                  end else begin
                     i_len[15:8] <= uart_rx_data;
                     i_count     <= '0;
                     i_idx       <= '0;
                     i_csum      <= '0;
                     i_timer     <= '0;
                     i_state     <= I_PAYLOAD;
                  end
               end else if (rx_timeout) begin
                  rx_drops <= rx_drops + 16'd1;
                  i_state  <= I_LEN_LO;
               end else begin
                  i_timer <= i_timer + TW'(1);
               end
            end
            I_PAYLOAD: begin
               if (uart_rx_valid) begin
                  i_count <= i_count + AW'(1);
                  i_csum  <= i_csum + uart_rx_data;
                  i_timer <= '0;
                  if (payload_last) begin
`ifdef MP64_NIC_BRIDGE_CSUM_EN
                     i_state <= I_CSUM;
`else
                     i_state <= I_WAIT;
`endif
                  end
               end else if (rx_timeout) begin
                  rx_drops <= rx_drops + 16'd1;
                  i_state  <= I_LEN_LO;
               end else begin
                  i_timer <= i_timer + TW'(1);
               end
            end
`ifdef MP64_NIC_BRIDGE_CSUM_EN
            I_CSUM: begin
               if (uart_rx_valid) begin
                  if (uart_rx_data == i_csum) begin
                     i_state <= I_WAIT;
                  end else begin
                     rx_drops <= rx_drops + 16'd1;
                     i_state  <= I_LEN_LO;
                  end
               end else if (rx_timeout) begin
                  rx_drops <= rx_drops + 16'd1;
                  i_state  <= I_LEN_LO;
               end else begin
                  i_timer <= i_timer + TW'(1);
               end
            end
`endif
            I_WAIT: begin
               if (uart_rx_valid) rx_drops <= rx_drops + 16'd1;
               if (nic_rx_ready) begin
                  nic_rx_valid <= 1'b1;
                  nic_rx_data  <= rx_rd;
                  i_idx        <= i_idx + AW'(1);
                  i_state      <= I_STREAM;
               end
            end
            I_STREAM: begin
               if (uart_rx_valid) rx_drops <= rx_drops + 16'd1;
               if (stream_done) begin
                  nic_rx_valid <= 1'b0;
                  rx_frames    <= rx_frames + 16'd1;
                  i_state      <= I_LEN_LO;
               end else begin
                  nic_rx_data <= rx_rd;
                  i_idx       <= i_idx + AW'(1);
               end
            end
            default: i_state <= I_LEN_LO;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) link_up <= 1'b0;
      else        link_up <= 1'b1;
   end

endmodule

// File: tb/tb_mp64_nic_uart_bridge.sv
// Scoreboard bench for mp64_nic_uart_bridge: queued expected UART and NIC bytes, per-scenario tasks.
module tb_mp64_nic_uart_bridge;

   localparam int unsigned MTU        = 1500;
   localparam int unsigned GAP_CYCLES = 16;
   localparam int unsigned RX_TIMEOUT = 65535;

   logic        clk;
   logic        rst_n;
   logic        nic_tx_valid;
   logic [7:0]  nic_tx_data;
   logic        nic_tx_ready;
   logic        nic_rx_valid;
   logic [7:0]  nic_rx_data;
   logic        nic_rx_ready;
   logic        link_up;
   logic        uart_tx_valid;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_ready;
   logic        uart_rx_valid;
   logic [7:0]  uart_rx_data;
   logic [15:0] tx_frames;
   logic [15:0] rx_frames;
   logic [15:0] rx_drops;
   logic [15:0] tx_drops;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] uart_exp[$];
   logic [7:0] rx_exp[$];
   logic [7:0] stim[$];
   int uart_pops = 0;
   int rx_run = 0;
   int last_run = 0;
   logic [7:0] uart_want;
   logic [7:0] rx_want;
   logic [15:0] exp_rx_drops = 16'd0;

   mp64_nic_uart_bridge dut (
      .clk(clk), .rst_n(rst_n),
      .nic_tx_valid(nic_tx_valid), .nic_tx_data(nic_tx_data), .nic_tx_ready(nic_tx_ready),
      .nic_rx_valid(nic_rx_valid), .nic_rx_data(nic_rx_data), .nic_rx_ready(nic_rx_ready),
      .link_up(link_up),
      .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready),
      .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
      .tx_frames(tx_frames), .rx_frames(rx_frames), .rx_drops(rx_drops), .tx_drops(tx_drops)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitors on the falling edge: every UART transfer and NIC byte is checked against the queues.
   always @(negedge clk) begin
      if (uart_tx_valid && uart_tx_ready) begin
         vectors++;
         if (uart_exp.size() == 0) begin
            miscompares++;
            $display("FAIL uart_unexpected got %02h want none", uart_tx_data);
         end else begin
            uart_want = uart_exp.pop_front();
            if (uart_tx_data !== uart_want) begin
               miscompares++;
               $display("FAIL uart_byte got %02h want %02h", uart_tx_data, uart_want);
            end
         end
         uart_pops++;
      end
      if (nic_rx_valid) begin
         vectors++;
         rx_run++;
         if (rx_exp.size() == 0) begin
            miscompares++;
            $display("FAIL nic_rx_unexpected got %02h want none", nic_rx_data);
         end else begin
            rx_want = rx_exp.pop_front();
            if (nic_rx_data !== rx_want) begin
               miscompares++;
               $display("FAIL nic_rx_byte got %02h want %02h", nic_rx_data, rx_want);
            end
         end
      end else if (rx_run != 0) begin
         last_run = rx_run;
         rx_run = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_egress();
      logic [7:0] sum;
      int len;
      sum = 8'h00;
      len = stim.size();
      uart_exp.push_back(8'(len));
      uart_exp.push_back(8'(len >> 8));
      foreach (stim[i]) begin
         uart_exp.push_back(stim[i]);
         sum = sum + stim[i];
      end
`ifdef MP64_NIC_BRIDGE_CSUM_EN
      uart_exp.push_back(sum);
`endif
   endtask

   task automatic nic_send();
      int n;
      n = 0;
      while (!nic_tx_ready && n < 100) begin tick(); n++; end
      vectors++;
      if (!nic_tx_ready) begin
         miscompares++;
         $display("FAIL nic_tx_ready_wait got %0b want 1", nic_tx_ready);
      end
      foreach (stim[i]) begin
         nic_tx_valid = 1'b1;
         nic_tx_data  = stim[i];
         tick();
      end
      nic_tx_valid = 1'b0;
   endtask

   task automatic drain_uart(input int budget);
      int n;
      n = 0;
      while ((uart_exp.size() != 0 || uart_tx_valid) && n < budget) begin tick(); n++; end
      vectors++;
      if (uart_exp.size() != 0 || uart_tx_valid) begin
         miscompares++;
         $display("FAIL uart_drain got %0d pending want 0", uart_exp.size());
      end
   endtask

   task automatic uart_byte(input logic [7:0] b);
      uart_rx_valid = 1'b1;
      uart_rx_data  = b;
      tick();
      uart_rx_valid = 1'b0;
   endtask

   task automatic uart_frame(input logic push);
      logic [7:0] sum;
      sum = 8'h00;
      uart_byte(8'(stim.size()));
      uart_byte(8'(stim.size() >> 8));
      foreach (stim[i]) begin
         uart_byte(stim[i]);
         sum = sum + stim[i];
         if (push) rx_exp.push_back(stim[i]);
      end
`ifdef MP64_NIC_BRIDGE_CSUM_EN
      uart_byte(sum);
`endif
   endtask

   task automatic drain_rx(input int budget);
      int n;
      n = 0;
      while ((rx_exp.size() != 0 || nic_rx_valid) && n < budget) begin tick(); n++; end
      tick();
      vectors++;
      if (rx_exp.size() != 0 || nic_rx_valid) begin
         miscompares++;
         $display("FAIL nic_rx_drain got %0d pending want 0", rx_exp.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      nic_tx_valid = 1'b0; nic_tx_data = '0; nic_rx_ready = 1'b0;
      uart_tx_ready = 1'b1; uart_rx_valid = 1'b0; uart_rx_data = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({nic_tx_ready, nic_rx_valid, link_up, uart_tx_valid} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags got %04b want 0000", {nic_tx_ready, nic_rx_valid, link_up, uart_tx_valid});
      end
      vectors++;
      if ({tx_frames, rx_frames, rx_drops, tx_drops} !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_counters got %h want 0", {tx_frames, rx_frames, rx_drops, tx_drops});
      end
      rst_n = 1'b1;
      tick();
      vectors++;
      if ({link_up, nic_tx_ready} !== 2'b11) begin
         miscompares++;
         $display("FAIL post_reset got %02b want 11", {link_up, nic_tx_ready});
      end
   endtask

   task automatic test_egress();
      int n;
      stim = '{8'h11, 8'h22, 8'h33};
      push_egress();
      nic_send();
      n = 0;
      while (!uart_tx_valid && n < 40) begin tick(); n++; end
      vectors++;
      if (n != GAP_CYCLES) begin
         miscompares++;
         $display("FAIL egress_gap got %0d want %0d", n, GAP_CYCLES);
      end
      drain_uart(100);
      tick();
      vectors++;
      if (tx_frames !== 16'd1) begin
         miscompares++;
         $display("FAIL egress_tx_frames got %0d want 1", tx_frames);
      end
   endtask

   task automatic test_backpressure();
      int p0;
      int n;
      logic [7:0] held;
      stim.delete();
      for (int i = 0; i < 8; i++) stim.push_back(8'hA0 + 8'(i));
      push_egress();
      p0 = uart_pops;
      nic_send();
      n = 0;
      while (uart_pops < p0 + 4 && n < 200) begin tick(); n++; end
      uart_tx_ready = 1'b0;
      held = (uart_exp.size() != 0) ? uart_exp[0] : 8'h00;
      for (int c = 0; c < 10; c++) begin
         tick();
         vectors++;
         if ({uart_tx_valid, uart_tx_data, nic_tx_ready} !== {1'b1, held, 1'b0}) begin
            miscompares++;
            $display("FAIL backpressure_hold got v=%0b d=%02h r=%0b want v=1 d=%02h r=0",
                     uart_tx_valid, uart_tx_data, nic_tx_ready, held);
         end
      end
      uart_tx_ready = 1'b1;
      drain_uart(100);
      tick();
      vectors++;
      if (tx_frames !== 16'd2) begin
         miscompares++;
         $display("FAIL backpressure_tx_frames got %0d want 2", tx_frames);
      end
   endtask

   task automatic test_ingress();
      nic_rx_ready = 1'b1;
      stim = '{8'hAA, 8'hBB};
      uart_frame(1'b1);
      drain_rx(50);
      vectors++;
      if (last_run != 2) begin
         miscompares++;
         $display("FAIL ingress_run got %0d want 2", last_run);
      end
      vectors++;
      if ({rx_frames, rx_drops} !== {16'd1, exp_rx_drops}) begin
         miscompares++;
         $display("FAIL ingress_counters got %0d/%0d want 1/%0d", rx_frames, rx_drops, exp_rx_drops);
      end
   endtask

   task automatic test_holdoff();
      int n;
      logic seen;
      nic_rx_ready = 1'b0;
      stim = '{8'h5A};
      uart_frame(1'b1);
      seen = 1'b0;
      repeat (20) begin tick(); seen = seen | nic_rx_valid; end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL holdoff_valid got 1 want 0");
      end
      uart_byte(8'hEE);
      uart_byte(8'hEF);
      tick();
      exp_rx_drops = exp_rx_drops + 16'd2;
      vectors++;
      if (rx_drops !== exp_rx_drops) begin
         miscompares++;
         $display("FAIL holdoff_drops got %0d want %0d", rx_drops, exp_rx_drops);
      end
      nic_rx_ready = 1'b1;
      n = 0;
      while (!nic_rx_valid && n < 10) begin tick(); n++; end
      vectors++;
      if (n < 1 || n > 2) begin
         miscompares++;
         $display("FAIL holdoff_latency got %0d want 1..2", n);
      end
      drain_rx(50);
      vectors++;
      if ({last_run, rx_frames} !== {32'd1, 16'd2}) begin
         miscompares++;
         $display("FAIL holdoff_run got run=%0d frames=%0d want 1/2", last_run, rx_frames);
      end
   endtask

   task automatic test_bad_length();
      uart_byte(8'hDD);
      uart_byte(8'h05);
      uart_byte(8'h00);
      uart_byte(8'h00);
      repeat (4) tick();
      exp_rx_drops = exp_rx_drops + 16'd2;
      vectors++;
      if (rx_drops !== exp_rx_drops) begin
         miscompares++;
         $display("FAIL bad_length_drops got %0d want %0d", rx_drops, exp_rx_drops);
      end
      uart_byte(8'h04);
      uart_byte(8'h00);
      uart_byte(8'hAA);
      repeat (RX_TIMEOUT - 1) tick();
      vectors++;
      if (rx_drops !== exp_rx_drops) begin
         miscompares++;
         $display("FAIL timeout_early got %0d want %0d", rx_drops, exp_rx_drops);
      end
      tick();
      exp_rx_drops = exp_rx_drops + 16'd1;
      vectors++;
      if (rx_drops !== exp_rx_drops) begin
         miscompares++;
         $display("FAIL timeout_drop got %0d want %0d", rx_drops, exp_rx_drops);
      end
      stim = '{8'hC3, 8'h3C, 8'h01};
      uart_frame(1'b1);
      drain_rx(50);
      vectors++;
      if ({last_run, rx_frames, rx_drops} !== {32'd3, 16'd3, exp_rx_drops}) begin
         miscompares++;
         $display("FAIL after_timeout got run=%0d frames=%0d drops=%0d want 3/3/%0d",
                  last_run, rx_frames, rx_drops, exp_rx_drops);
      end
   endtask

   task automatic test_overflow();
      stim.delete();
      for (int i = 0; i < MTU + 1; i++) stim.push_back(8'(i));
      nic_send();
      repeat (GAP_CYCLES + 5) tick();
      vectors++;
      if ({tx_drops, tx_frames, uart_tx_valid} !== {16'd1, 16'd2, 1'b0}) begin
         miscompares++;
         $display("FAIL overflow got drops=%0d frames=%0d valid=%0b want 1/2/0",
                  tx_drops, tx_frames, uart_tx_valid);
      end
      stim = '{8'h7E};
      push_egress();
      nic_send();
      drain_uart(100);
      tick();
      vectors++;
      if ({tx_frames, tx_drops} !== {16'd3, 16'd1}) begin
         miscompares++;
         $display("FAIL overflow_next got frames=%0d drops=%0d want 3/1", tx_frames, tx_drops);
      end
   endtask

   initial begin
      test_reset();
      test_egress();
      test_backpressure();
      test_ingress();
      test_holdoff();
      test_bad_length();
      test_overflow();
      repeat (5) tick();
      vectors++;
      if (uart_exp.size() + rx_exp.size() != 0) begin
         miscompares++;
         $display("FAIL leftover got %0d want 0", uart_exp.size() + rx_exp.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mp64_nic_uart_bridge.md
# mp64_nic_uart_bridge

PHY-side bridge that terminates the NIC's byte-stream PHY interface and carries frames over a byte-wide UART link as length-prefixed packets. It provides the test-link alternative to an RMII or SPI Ethernet PHY. It sits between the NIC PHY port and a UART byte transceiver, with one frame buffer per direction. The egress path turns NIC TX bursts into UART packets; the ingress path turns UART packets into contiguous NIC RX bursts.

## Interface
- MTU, 1500: maximum payload bytes per frame, in either direction.
- GAP_CYCLES, 16: idle cycles on nic_tx_valid that end an egress frame.
- RX_TIMEOUT, 65535: maximum idle cycles between UART bytes inside an ingress packet.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- nic_tx_valid  in  1  NIC egress byte valid.
- nic_tx_data  in  8  NIC egress byte.
- nic_tx_ready  out  1  bridge can accept egress bytes.
- nic_rx_valid  out  1  ingress byte valid to NIC.
- nic_rx_data  out  8  ingress byte.
- nic_rx_ready  in  1  NIC ready to begin a frame.
- link_up  out  1  link status to NIC.
- uart_tx_valid  out  1  byte to UART transmitter.
- uart_tx_data  out  8  byte to UART transmitter.
- uart_tx_ready  in  1  UART transmitter accepts the byte.
- uart_rx_valid  in  1  one-cycle strobe: UART byte received.
- uart_rx_data  in  8  received UART byte.
- tx_frames  out  16  egress frames sent; wraps.
- rx_frames  out  16  ingress frames delivered; wraps.
- rx_drops  out  16  ingress frames or bytes discarded; wraps.
- tx_drops  out  16  egress frames discarded; wraps.

## Operation
- Wire format: LEN_LO, LEN_HI (16-bit little-endian payload length), payload bytes, then an optional checksum (see Configuration).
- Egress FSM:
  - E_IDLE: first valid byte is stored at index 0, count=1, go to E_CAPTURE.
  - E_CAPTURE: each valid byte is stored at index count, count++, and the gap counter clears. An invalid cycle increments the gap counter. When the gap counter reaches GAP_CYCLES, go to E_LEN_LO.
  - E_LEN_LO → E_LEN_HI → E_PAYLOAD → (E_CSUM) → E_IDLE. The last step increments tx_frames.
- nic_tx_ready is 1 only in E_IDLE and E_CAPTURE. Any byte with nic_tx_valid=1 in those states is stored; in-flight bytes are never lost.
- Egress overflow: a byte arriving when count=MTU sets a truncate flag. The frame is discarded at gap expiry, tx_drops is incremented, and the FSM returns to E_IDLE. Nothing is sent on UART.
- Ingress FSM:
  - I_LEN_LO → I_LEN_HI: length assembled.
  - If length==0 or length>MTU: rx_drops++, return to I_LEN_LO.
  - I_PAYLOAD stores length bytes, then (I_CSUM) → I_WAIT.
  - I_WAIT: wait for nic_rx_ready=1.
  - I_STREAM: drive length bytes, then rx_frames++ and return to I_LEN_LO.
- Ingress timeout: in I_LEN_HI, I_PAYLOAD or I_CSUM, RX_TIMEOUT idle cycles → rx_drops++, return to I_LEN_LO.
- UART bytes arriving in I_WAIT or I_STREAM are discarded; rx_drops is incremented once per byte.
- link_up is 0 in reset and goes to 1 on the first clock after rst_n deasserts.
- Egress and ingress paths are fully independent and may run simultaneously.

## Timing
- Reset values: all outputs 0, counters 0, FSMs in E_IDLE and I_LEN_LO. nic_tx_ready goes to 1 on the first clock after reset.
- Egress byte capture: zero-latency; the byte is stored on the sampling edge.
- uart_tx_valid:
  - Asserts on the cycle after gap expiry.
  - A byte transfers on any edge where uart_tx_valid and uart_tx_ready are both 1.
  - Data is held stable while valid=1 and ready=0.
  - Bubbles between bytes are permitted.
- nic_rx_valid:
  - Asserts within 2 cycles of I_WAIT observing nic_rx_ready=1.
  - Then stays high for exactly length consecutive cycles, with no bubbles; the NIC treats a drop in valid as end of frame.
  - nic_rx_ready is ignored during I_STREAM.
- Ingress capture: one byte per uart_rx_valid strobe; back-to-back strobes are supported.
- Reset mid-frame: both buffers are abandoned and nothing partial is emitted after reset.

## Configuration
- MP64_NIC_BRIDGE_CSUM_EN defined:
  - Egress appends one checksum byte equal to the 8-bit sum of the payload bytes, mod 256.
  - Ingress checks the checksum in I_CSUM. On mismatch: rx_drops++, frame not delivered, return to I_LEN_LO.
  - The checksum byte is not counted in the length.
- Macro undefined: the E_CSUM and I_CSUM states are absent and the wire format is length plus payload only.

## Test plan
- Egress frame: NIC sends 0x11,0x22,0x33 back-to-back, then idles ≥16 cycles → UART carries 03 00 11 22 33 (plus checksum 66 with the macro defined), and tx_frames=1.
- UART back-pressure: hold uart_tx_ready=0 for 10 cycles mid-payload → uart_tx_data stays stable, no byte lost or repeated, nic_tx_ready=0 throughout.
- Ingress frame: UART delivers 02 00 AA BB with nic_rx_ready=1 → nic_rx_valid high for exactly 2 consecutive cycles carrying AA then BB, and rx_frames=1.
- Ingress hold-off: nic_rx_ready=0 when the frame completes → no valid until ready=1. Extra UART bytes during the wait increment rx_drops by one each.
- Bad length or timeout: length 0x05DD (1501) → rx_drops++ and no output. A header 04 00 AA followed by RX_TIMEOUT idle cycles → rx_drops++, then a following good frame is delivered intact.
- Egress overflow: 1501 bytes from the NIC → no UART output and tx_drops=1. A next frame of 1 byte is sent correctly.
